// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that shares one register-file write port among NREQ 4-phase req/ack writers.
// Optional macro RF_ARB_TIMEOUT_EN bounds the wait for rf_ack to TIMEOUT cycles and raises a sticky timeout_err.
module rf_write_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         ack_o,
  input  logic [NREQ*AW-1:0]      addr_i,
  input  logic [NREQ*DW-1:0]      data_i,
  output logic                    rf_req,
  output logic                    rf_we,
  output logic [AW-1:0]           rf_addr,
  output logic [DW-1:0]           rf_data,
  input  logic                    rf_ack,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    busy,
  output logic                    timeout_err
);
  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("rf_write_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rf_write_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, RF_REQ, RF_REL, CLI_ACK} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] ack_d, ack_onehot;
  logic            rf_req_d, busy_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   data_d;
  logic [IW-1:0]   grant_d, last_grant, last_d;

  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_arr[k] = addr_i[k*AW +: AW];
    assign data_arr[k] = data_i[k*DW +: DW];
  end

  // Round-robin search starting just after the last writer served.
  logic [NREQ-1:0] req_pend;
  logic [IW-1:0]   cand, pick;
  logic            found;

  always_comb begin
    req_pend = req_i & ~ack_o;
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NREQ);
      if (!found && req_pend[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef RF_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_err_d;
`endif

  always_comb begin
    // NOTE: every next value defaults to holding its register, so no branch of the case leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    ack_d    = ack_o;
    rf_req_d = rf_req;
    addr_d   = rf_addr;
    data_d   = rf_data;
    grant_d  = grant_idx;
    busy_d   = busy;
    last_d   = last_grant;
    ack_onehot            = '0;
    ack_onehot[grant_idx] = 1'b1;
`ifdef RF_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = timeout_err;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          addr_d   = addr_arr[pick];
          data_d   = data_arr[pick];
          rf_req_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = RF_REQ;
`ifdef RF_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      RF_REQ: begin
        if (rf_ack) begin
          rf_req_d = 1'b0;
          state_d  = RF_REL;
        end
`ifdef RF_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
          // Give up on the register file but still ack the writer so its handshake completes.
          rf_req_d  = 1'b0;
          tmo_err_d = 1'b1;
          ack_d     = ack_onehot;
          state_d   = CLI_ACK;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      RF_REL: begin
        if (!rf_ack) begin
          ack_d   = ack_onehot;
          state_d = CLI_ACK;
        end
      end
      CLI_ACK: begin
        if (!req_i[grant_idx]) begin
          ack_d   = '0;
          last_d  = grant_idx;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop captures pre-edge values independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ack_o      <= '0;
      rf_req     <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
      grant_idx  <= '0;
      busy       <= 1'b0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      ack_o      <= ack_d;
      rf_req     <= rf_req_d;
      rf_addr    <= addr_d;
      rf_data    <= data_d;
      grant_idx  <= grant_d;
      busy       <= busy_d;
      last_grant <= last_d;
    end
  end

  assign rf_we = rf_req;

`ifdef RF_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q   <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_err <= tmo_err_d;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
